// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a RUN / FLUSH / HALT state machine.
// Handles sequential fetch, branch/JAL and JALR redirects with a timed flush
// window, trap entry into HALT, and resume out of HALT.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect target traps instead of being silently aligned.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_selection,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_result,
  input  logic        stall,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        halted,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JALR = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;
  localparam logic [1:0] SEL_TRAP = 2'b11;

  // Flush counter load value; the counter is 3 bits wide to cover 1..7.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] pc_inc_s;
  logic [31:0] target_s;
  logic        redirect_s;

`ifdef MISALIGN_TRAP_EN
  // A redirect target is misaligned when it is not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction
`endif

  // Sequential successor; the 32-bit add wraps naturally at the top of memory.
  assign pc_inc_s = pc_q + 32'd4;
  assign pc_plus4 = pc_inc_s;

  assign pc         = pc_q;
  assign flush      = flush_q;
  assign halted     = halted_q;
  assign misaligned = misaligned_q;

  // Select the raw redirect target: JALR clears bit 0 of rs1+imm, branches use the adder.
  always_comb begin
    target_s   = branch_target;
    redirect_s = 1'b0;
    if (pc_selection == SEL_JALR) begin
      target_s   = alu_result & 32'hFFFF_FFFE;
      redirect_s = 1'b1;
    end else if (pc_selection == SEL_BR) begin
      target_s   = branch_target;
      redirect_s = 1'b1;
    end else begin
      target_s   = branch_target;
      redirect_s = 1'b0;
    end
  end

  // Next-state logic: everything holds unless the pipeline is unstalled.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (pc_selection == SEL_TRAP) begin
            pc_d     = TRAP_VECTOR;
            halted_d = 1'b1;
            flush_d  = 1'b0;
            state_d  = ST_HALT;
          end else if (redirect_s) begin
`ifdef MISALIGN_TRAP_EN
            if (is_misaligned(target_s)) begin
              pc_d         = TRAP_VECTOR;
              halted_d     = 1'b1;
              misaligned_d = 1'b1;
              flush_d      = 1'b0;
              state_d      = ST_HALT;
            end else begin
              pc_d    = target_s;
              cnt_d   = FLUSH_LOAD;
              flush_d = 1'b1;
              state_d = ST_FLUSH;
            end
`else
            pc_d    = target_s & 32'hFFFF_FFFC;
            cnt_d   = FLUSH_LOAD;
            flush_d = 1'b1;
            state_d = ST_FLUSH;
`endif
          end else begin
            pc_d = pc_inc_s;
          end
        end
        ST_FLUSH: begin
          pc_d = pc_inc_s;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            flush_d = 1'b0;
            state_d = ST_RUN;
          end else begin
            cnt_d   = cnt_q - 3'd1;
            flush_d = 1'b1;
          end
        end
        ST_HALT: begin
          flush_d = 1'b0;
          if (resume) begin
            halted_d     = 1'b0;
            misaligned_d = 1'b0;
            state_d      = ST_RUN;
          end else begin
            halted_d = 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean RUN state.
          state_d  = ST_RUN;
          cnt_d    = 3'd0;
          flush_d  = 1'b0;
          halted_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      cnt_q        <= 3'd0;
      flush_q      <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with an expected-value scoreboard.
// Expected values are pushed when a step is driven and popped after the edge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_selection;
  logic [31:0] branch_target;
  logic [31:0] alu_result;
  logic        stall;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        halted;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc_selection (pc_selection),
    .branch_target(branch_target),
    .alu_result   (alu_result),
    .stall        (stall),
    .resume       (resume),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .flush        (flush),
    .halted       (halted),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop one expectation and compare every observable output against it.
  task automatic check_out();
    exp_t        e;
    string       t;
    logic [31:0] e_p4;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got 0 entries exp 1");
      return;
    end
    e    = exp_q.pop_front();
    t    = tag_q.pop_front();
    e_p4 = e.pc + 32'd4;
    checks++;
    assert (pc === e.pc) else begin
      errors++;
      $error("FAIL %s pc got %h exp %h", t, pc, e.pc);
    end
    checks++;
    assert (pc_plus4 === e_p4) else begin
      errors++;
      $error("FAIL %s pc_plus4 got %h exp %h", t, pc_plus4, e_p4);
    end
    checks++;
    assert (flush === e.flush) else begin
      errors++;
      $error("FAIL %s flush got %b exp %b", t, flush, e.flush);
    end
    checks++;
    assert (halted === e.halted) else begin
      errors++;
      $error("FAIL %s halted got %b exp %b", t, halted, e.halted);
    end
    checks++;
    assert (misaligned === e.mis) else begin
      errors++;
      $error("FAIL %s misaligned got %b exp %b", t, misaligned, e.mis);
    end
  endtask

  // Check the outputs right now, without waiting for a clock edge.
  task automatic check_now(input string tag, input logic [31:0] e_pc,
                           input logic e_fl, input logic e_h, input logic e_m);
    exp_q.push_back('{pc: e_pc, flush: e_fl, halted: e_h, mis: e_m});
    tag_q.push_back(tag);
    check_out();
  endtask

  // Drive one cycle of stimulus, record its expected result, and check after the edge.
  task automatic step(input string tag, input logic [1:0] sel, input logic [31:0] bt,
                      input logic [31:0] alu, input logic st, input logic rs,
                      input logic [31:0] e_pc, input logic e_fl, input logic e_h,
                      input logic e_m);
    @(negedge clk);
    pc_selection  = sel;
    branch_target = bt;
    alu_result    = alu;
    stall         = st;
    resume        = rs;
    exp_q.push_back('{pc: e_pc, flush: e_fl, halted: e_h, mis: e_m});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Quiet all inputs, used around resets.
  task automatic idle_inputs();
    pc_selection  = 2'b00;
    branch_target = 32'h0;
    alu_result    = 32'h0;
    stall         = 1'b0;
    resume        = 1'b0;
  endtask

  // Assert reset between edges, check it acts without a clock, then release after an edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #2;
    check_now({tag, "_async"}, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_now({tag, "_held"}, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  // Directed stimulus sequence.
  initial begin
    rst = 1'b0;
    idle_inputs();
    #3;
    check_now("reset_async", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_now("reset_release", 32'h0, 1'b0, 1'b0, 1'b0);

    // Sequential fetch.
    step("seq1", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);
    step("seq2", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);

    // Branch with a two-cycle flush window; a branch request during flush is ignored.
    step("br_take",   2'b10, 32'h40,  32'h0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
    step("br_flush2", 2'b10, 32'h999, 32'h0, 1'b0, 1'b0, 32'h44, 1'b1, 1'b0, 1'b0);
    step("br_run",    2'b00, 32'h0,   32'h0, 1'b0, 1'b0, 32'h48, 1'b0, 1'b0, 1'b0);
    // Resume outside HALT has no effect.
    step("resume_run", 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4C, 1'b0, 1'b0, 1'b0);
    // Stall in RUN beats a branch request.
    step("stall_run", 2'b10, 32'h500, 32'h0, 1'b1, 1'b0, 32'h4C, 1'b0, 1'b0, 1'b0);

    // JALR clears bit 0 of the sum.
    step("jalr",      2'b01, 32'h0, 32'h81, 1'b0, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
    step("jalr_fl2",  2'b00, 32'h0, 32'h0,  1'b0, 1'b0, 32'h84, 1'b1, 1'b0, 1'b0);
    step("jalr_run",  2'b00, 32'h0, 32'h0,  1'b0, 1'b0, 32'h88, 1'b0, 1'b0, 1'b0);

`ifdef MISALIGN_TRAP_EN
    step("mis_trap",   2'b01, 32'h0, 32'h82, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1);
    step("mis_hold",   2'b00, 32'h0, 32'h0,  1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1);
    step("mis_resume", 2'b00, 32'h0, 32'h0,  1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step("mis_run",    2'b00, 32'h0, 32'h0,  1'b0, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0);
`else
    // Misaligned targets are aligned down and redirect normally.
    step("mis_align",  2'b01, 32'h0,  32'h82, 1'b0, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
    step("mis_fl2",    2'b00, 32'h0,  32'h0,  1'b0, 1'b0, 32'h84, 1'b1, 1'b0, 1'b0);
    step("mis_run",    2'b00, 32'h0,  32'h0,  1'b0, 1'b0, 32'h88, 1'b0, 1'b0, 1'b0);
    step("br_align",   2'b10, 32'h93, 32'h0,  1'b0, 1'b0, 32'h90, 1'b1, 1'b0, 1'b0);
    step("br_al_fl2",  2'b00, 32'h0,  32'h0,  1'b0, 1'b0, 32'h94, 1'b1, 1'b0, 1'b0);
    step("br_al_run",  2'b00, 32'h0,  32'h0,  1'b0, 1'b0, 32'h98, 1'b0, 1'b0, 1'b0);
`endif

    // Trap into HALT; pc holds and pc_selection is ignored for 5 cycles.
    step("trap", 2'b11, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("halt_hold", 2'(i % 4), 32'h300, 32'h300, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0);
    end
    // Stall beats resume.
    step("halt_stall_resume", 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    step("resume",     2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step("after_resume", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0);

    // Stall for 3 cycles mid-flush: flush still lasts exactly 2 unstalled cycles.
    step("fl_take",   2'b10, 32'h200, 32'h0, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("fl_stall", 2'b01, 32'h0, 32'h55, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0);
    end
    step("fl_cyc2",   2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0);
    step("fl_stall2", 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0);
    step("fl_done",   2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h208, 1'b0, 1'b0, 1'b0);

    // Reset mid-HALT.
    step("trap2", 2'b11, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0);
    pulse_reset("rst_halt");
    step("rst_halt_run", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);

    // Reset mid-FLUSH.
    step("fl3_take", 2'b10, 32'h300, 32'h0, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0);
    pulse_reset("rst_flush");
    step("rst_flush_run", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);

    // Wrap at the top of the address space.
    step("wrap_take", 2'b10, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    step("wrap_0",    2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step("wrap_run",  2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
